// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap controller:
// CSR addresses, operation encodings, mstatus bit positions, FSM states and cause codes.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [4:0] EXC_ILLEGAL_INSTR = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT    = 5'd3;
  localparam logic [4:0] EXC_ECALL_M       = 5'd11;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } trap_state_e;

  // Trap waiting for the core: for interrupts code is the source index, epc/tval unused.
  typedef struct packed {
    logic        is_irq;
    logic [4:0]  code;
    logic [31:0] tval;
    logic [31:0] epc;
  } trap_cand_t;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: return wdata;
      CSR_OP_SET:   return old_val | wdata;
      CSR_OP_CLEAR: return old_val & ~wdata;
      default:      return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt arbiter: the lowest-index eligible source wins.
module csr_irq_arbiter
  import csr_pkg::*;
#(
  parameter int NUM_IRQ = 16
) (
  input  logic [NUM_IRQ-1:0] eligible_i,
  output logic               any_valid_o,
  output logic [4:0]         idx_o
);

  // NOTE: every output gets a default before the loop, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    any_valid_o = |eligible_i;
    idx_o       = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible_i[i]) idx_o = 5'(i);
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller with prioritised interrupts and exceptions.
// Optional mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int          NUM_IRQ     = 16,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int          HART_ID     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  input  logic [1:0]         csr_op,
  output logic [31:0]        csr_rdata,
  input  logic [NUM_IRQ-1:0] irq_pend,
  input  logic               exc_valid,
  input  logic [4:0]         exc_cause,
  input  logic [31:0]        exc_tval,
  input  logic [31:0]        exc_pc,
  input  logic [31:0]        pc_next,
  input  logic               trap_ack,
  input  logic               mret,
  output logic               trap_req,
  output logic [31:0]        trap_vector,
  output logic [31:0]        mepc_out,
  output logic               mstatus_mie
`ifdef CSR_COUNTERS_EN
  ,
  input  logic               instr_retire
`endif
);

  localparam logic [31:0] MIE_MASK = 32'((64'd1 << NUM_IRQ) - 64'd1);

  trap_state_e        state_q, state_d;
  trap_cand_t         cand_q, cand_d;
  logic               trap_req_q, trap_req_d;
  logic               mie_bit_q, mie_bit_d;
  logic               mpie_q, mpie_d;
  logic [31:0]        mie_q, mie_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mscratch_q, mscratch_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [31:0]        mtval_q, mtval_d;
  logic [NUM_IRQ-1:0] mip_q;
  logic [31:0]        rdata_q;
`ifdef CSR_COUNTERS_EN
  logic [63:0]        mcycle_q, mcycle_d;
  logic [63:0]        minstret_q, minstret_d;
`endif

  csr_op_e      op;
  logic         wr_en;
  logic [31:0]  mstatus_rd;
  logic [31:0]  rd_val;
  logic [31:0]  wval;
  logic         irq_valid;
  logic [4:0]   irq_idx;
  logic [31:0]  tvec_base;

  assign op    = csr_op_e'(csr_op);
  assign wr_en = (op != CSR_OP_NONE);

  always_comb begin
    mstatus_rd               = '0;
    mstatus_rd[MSTATUS_MIE]  = mie_bit_q;
    mstatus_rd[MSTATUS_MPIE] = mpie_q;
  end

  always_comb begin
    rd_val = '0;
    case (csr_addr)
      CSR_MSTATUS:   rd_val = mstatus_rd;
      CSR_MIE:       rd_val = mie_q;
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_q;
      CSR_MCAUSE:    rd_val = mcause_q;
      CSR_MTVAL:     rd_val = mtval_q;
      CSR_MIP:       rd_val = 32'(mip_q);
      CSR_MHARTID:   rd_val = 32'(HART_ID);
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    rd_val = mcycle_q[31:0];
      CSR_MCYCLEH:   rd_val = mcycle_q[63:32];
      CSR_MINSTRET:  rd_val = minstret_q[31:0];
      CSR_MINSTRETH: rd_val = minstret_q[63:32];
`endif
      default:       rd_val = '0;
    endcase
  end

  // Set/clear operate on the architecturally visible value, so masked bits stay masked.
  assign wval = csr_apply(op, rd_val, csr_wdata);

  csr_irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arbiter (
    .eligible_i  (mip_q & mie_q[NUM_IRQ-1:0] & {NUM_IRQ{mie_bit_q}}),
    .any_valid_o (irq_valid),
    .idx_o       (irq_idx)
  );

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    trap_req_d = trap_req_q;
    mie_bit_d  = mie_bit_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;

    // Ordering below sets precedence: mret, then CSR write, then trap commit wins last.
    if (mret && state_q == IDLE) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
    end

    if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_bit_d = wval[MSTATUS_MIE];
          mpie_d    = wval[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = wval & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = {wval[31:2], wval[1] ? 2'b00 : wval[1:0]};
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval;
        CSR_MCAUSE:   mcause_d   = wval;
        CSR_MTVAL:    mtval_d    = wval;
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          cand_d     = '{is_irq: 1'b0, code: exc_cause, tval: exc_tval, epc: exc_pc};
          state_d    = PEND;
          trap_req_d = 1'b1;
        end else if (irq_valid) begin
          cand_d     = '{is_irq: 1'b1, code: irq_idx, tval: 32'd0, epc: 32'd0};
          state_d    = PEND;
          trap_req_d = 1'b1;
        end
      end
      PEND: begin
        if (trap_ack) begin
          mepc_d     = cand_q.is_irq ? pc_next : cand_q.epc;
          mcause_d   = {cand_q.is_irq, 26'd0, cand_q.code};
          mtval_d    = cand_q.is_irq ? 32'd0 : cand_q.tval;
          mpie_d     = mie_bit_q;
          mie_bit_d  = 1'b0;
          state_d    = IDLE;
          trap_req_d = 1'b0;
        end else if (exc_valid && cand_q.is_irq) begin
          cand_d = '{is_irq: 1'b0, code: exc_cause, tval: exc_tval, epc: exc_pc};
        end
      end
      default: begin
        state_d    = IDLE;
        trap_req_d = 1'b0;
      end
    endcase
  end

`ifdef CSR_COUNTERS_EN
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + 64'(instr_retire);
    if (wr_en) begin
      case (csr_addr)
        CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wval};
        CSR_MCYCLEH:   mcycle_d   = {wval, mcycle_q[31:0]};
        CSR_MINSTRET:  minstret_d = {minstret_q[63:32], wval};
        CSR_MINSTRETH: minstret_d = {wval, minstret_q[31:0]};
        default: ;
      endcase
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      trap_req_q <= 1'b0;
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      trap_req_q <= trap_req_d;
      mie_bit_q  <= mie_bit_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mip_q      <= irq_pend;
      rdata_q    <= rd_val;
    end
  end

`ifdef CSR_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  assign tvec_base   = {mtvec_q[31:2], 2'b00};
  assign trap_vector = tvec_base + ((mtvec_q[1:0] == 2'b01 && cand_q.is_irq)
                                    ? {25'd0, cand_q.code, 2'b00} : 32'd0);
  assign trap_req    = trap_req_q;
  assign csr_rdata   = rdata_q;
  assign mepc_out    = mepc_q;
  assign mstatus_mie = mie_bit_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit: CSR access, interrupt/exception traps,
// mret, simultaneous-event precedence and reset during a pending trap.
module tb_csr_trap_unit;
  import csr_pkg::*;

  localparam int          NUM_IRQ     = 16;
  localparam logic [31:0] MTVEC_RESET = 32'h0000_0200;
  localparam int          HART_ID     = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic [11:0]        csr_addr;
  logic [31:0]        csr_wdata;
  logic [1:0]         csr_op;
  logic [31:0]        csr_rdata;
  logic [NUM_IRQ-1:0] irq_pend;
  logic               exc_valid;
  logic [4:0]         exc_cause;
  logic [31:0]        exc_tval;
  logic [31:0]        exc_pc;
  logic [31:0]        pc_next;
  logic               trap_ack;
  logic               mret;
  logic               trap_req;
  logic [31:0]        trap_vector;
  logic [31:0]        mepc_out;
  logic               mstatus_mie;
`ifdef CSR_COUNTERS_EN
  logic               instr_retire = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  csr_trap_unit #(
    .NUM_IRQ(NUM_IRQ), .MTVEC_RESET(MTVEC_RESET), .HART_ID(HART_ID)
  ) dut (
    .clk(clk), .reset(reset),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_op(csr_op), .csr_rdata(csr_rdata),
    .irq_pend(irq_pend),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .exc_pc(exc_pc),
    .pc_next(pc_next), .trap_ack(trap_ack), .mret(mret),
    .trap_req(trap_req), .trap_vector(trap_vector), .mepc_out(mepc_out),
    .mstatus_mie(mstatus_mie)
`ifdef CSR_COUNTERS_EN
    , .instr_retire(instr_retire)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic csr_do(input logic [11:0] a, input csr_op_e o, input logic [31:0] d);
    csr_addr  = a;
    csr_op    = o;
    csr_wdata = d;
    tick();
    csr_op    = CSR_OP_NONE;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    csr_op   = CSR_OP_NONE;
    tick();
    d = csr_rdata;
  endtask

  initial begin
    reset = 1'b1; csr_addr = '0; csr_wdata = '0; csr_op = CSR_OP_NONE;
    irq_pend = '0; exc_valid = 1'b0; exc_cause = '0; exc_tval = '0; exc_pc = '0;
    pc_next = 32'h4000_0010; trap_ack = 1'b0; mret = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_trap_req", 32'(trap_req), 32'd0);
    check("rst_mie", 32'(mstatus_mie), 32'd0);
    check("rst_mepc", mepc_out, 32'd0);
    check("rst_rdata", csr_rdata, 32'd0);
    csr_read(CSR_MTVEC, rd);   check("rst_mtvec", rd, MTVEC_RESET);
    csr_read(CSR_MCAUSE, rd);  check("rst_mcause", rd, 32'd0);
    csr_read(CSR_MHARTID, rd); check("mhartid", rd, 32'd5);
    csr_read(12'h7C0, rd);     check("unimpl_read", rd, 32'd0);

    // Direct-mode interrupt on source 7
    csr_do(CSR_MTVEC, CSR_OP_WRITE, 32'h0000_0100);
    csr_do(CSR_MIE, CSR_OP_WRITE, 32'h0000_0080);
    csr_do(CSR_MSTATUS, CSR_OP_WRITE, 32'h0000_0008);
    check("mie_after_write", 32'(mstatus_mie), 32'd1);
    irq_pend = 16'h0080;
    tick(); check("irq_lat1", 32'(trap_req), 32'd0);
    tick(); check("irq_lat2", 32'(trap_req), 32'd1);
    check("vec_direct", trap_vector, 32'h0000_0100);
    irq_pend = '0;
    tick(); check("cand_held", 32'(trap_req), 32'd1);
    check("vec_held", trap_vector, 32'h0000_0100);
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    check("ack_req_low", 32'(trap_req), 32'd0);
    check("irq_mepc", mepc_out, 32'h4000_0010);
    check("ack_mie_clr", 32'(mstatus_mie), 32'd0);
    csr_read(CSR_MCAUSE, rd);  check("irq7_mcause", rd, 32'h8000_0007);
    csr_read(CSR_MSTATUS, rd); check("irq7_mstatus", rd, 32'h0000_0080);

    // mret restores MIE from MPIE and sets MPIE
    mret = 1'b1; tick(); mret = 1'b0;
    check("mret_mie", 32'(mstatus_mie), 32'd1);
    check("mret_mepc", mepc_out, 32'h4000_0010);
    csr_read(CSR_MSTATUS, rd); check("mret_mstatus", rd, 32'h0000_0088);

    // mtvec mode legalisation, mie masking, vectored priority
    csr_do(CSR_MTVEC, CSR_OP_WRITE, 32'h0000_0103);
    csr_read(CSR_MTVEC, rd); check("mtvec_mode_1x", rd, 32'h0000_0100);
    csr_do(CSR_MTVEC, CSR_OP_WRITE, 32'h0000_0101);
    csr_read(CSR_MTVEC, rd); check("mtvec_vectored", rd, 32'h0000_0101);
    csr_do(CSR_MIE, CSR_OP_WRITE, 32'hFFFF_FFFF);
    csr_read(CSR_MIE, rd); check("mie_mask", rd, 32'h0000_FFFF);
    csr_do(CSR_MIE, CSR_OP_WRITE, 32'h0000_0208);
    pc_next = 32'h4000_0020;
    irq_pend = 16'h0208;
    tick(); tick();
    check("prio_req", 32'(trap_req), 32'd1);
    check("vec_irq3", trap_vector, 32'h0000_010C);
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    irq_pend = '0;
    csr_read(CSR_MCAUSE, rd); check("irq3_mcause", rd, 32'h8000_0003);
    check("irq3_mepc", mepc_out, 32'h4000_0020);

    // Exception overrides a pending interrupt; mret in PEND is ignored
    mret = 1'b1; tick(); mret = 1'b0;
    irq_pend = 16'h0200;
    tick(); tick();
    check("irq9_req", 32'(trap_req), 32'd1);
    check("vec_irq9", trap_vector, 32'h0000_0124);
    mret = 1'b1; tick(); mret = 1'b0;
    check("pend_mret_mie", 32'(mstatus_mie), 32'd1);
    check("pend_mret_req", 32'(trap_req), 32'd1);
    exc_valid = 1'b1; exc_cause = EXC_ILLEGAL_INSTR; exc_tval = 32'h0000_DEAD;
    exc_pc = 32'h4000_0100;
    tick(); exc_valid = 1'b0;
    check("vec_exc_base", trap_vector, 32'h0000_0100);
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    irq_pend = '0;
    check("exc_mepc", mepc_out, 32'h4000_0100);
    csr_read(CSR_MCAUSE, rd); check("exc_mcause", rd, 32'h0000_0002);
    csr_read(CSR_MTVAL, rd);  check("exc_mtval", rd, 32'h0000_DEAD);

    // Set/clear operations and read-only mip
    csr_do(CSR_MSCRATCH, CSR_OP_WRITE, 32'h0000_000F);
    csr_do(CSR_MSCRATCH, CSR_OP_SET, 32'h0000_00F0);
    csr_read(CSR_MSCRATCH, rd); check("mscratch_set", rd, 32'h0000_00FF);
    csr_do(CSR_MSCRATCH, CSR_OP_CLEAR, 32'h0000_00F0);
    csr_read(CSR_MSCRATCH, rd); check("mscratch_clr", rd, 32'h0000_000F);
    irq_pend = 16'h0005;
    csr_do(CSR_MIP, CSR_OP_WRITE, 32'h0000_FFFF);
    csr_read(CSR_MIP, rd); check("mip_readonly", rd, 32'h0000_0005);
    irq_pend = '0;

    // Exception with MIE=0; trap_ack beats a same-cycle mcause write
    exc_valid = 1'b1; exc_cause = EXC_ECALL_M; exc_tval = 32'h0000_0000;
    exc_pc = 32'h4000_0200;
    tick(); exc_valid = 1'b0;
    check("exc_req_1cyc", 32'(trap_req), 32'd1);
    trap_ack = 1'b1;
    csr_do(CSR_MCAUSE, CSR_OP_WRITE, 32'h0000_1234);
    trap_ack = 1'b0;
    csr_read(CSR_MCAUSE, rd); check("ack_beats_write", rd, 32'h0000_000B);
    check("ecall_mepc", mepc_out, 32'h4000_0200);

    // Reset while PEND abandons the trap
    exc_valid = 1'b1; exc_cause = EXC_BREAKPOINT; exc_pc = 32'h4000_0300;
    tick(); exc_valid = 1'b0;
    check("pre_rst_req", 32'(trap_req), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_pend_req", 32'(trap_req), 32'd0);
`ifdef CSR_COUNTERS_EN
    csr_read(CSR_MCYCLE, rd); check("mcycle_zero", rd, 32'd0);
    csr_read(CSR_MCYCLE, rd); check("mcycle_inc", rd, 32'd1);
`endif
    csr_read(CSR_MCAUSE, rd); check("rst_pend_mcause", rd, 32'd0);
    csr_read(CSR_MTVEC, rd);  check("rst_pend_mtvec", rd, MTVEC_RESET);
    check("rst_pend_mepc", mepc_out, 32'd0);
    tick();
    check("rst_no_retrap", 32'(trap_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Parametrised machine-mode CSR file and trap controller for the single-hart core. It replaces the fixed single-source interrupt CSR block and adds the following:
- N prioritised interrupt sources.
- Synchronous exceptions.
- An explicit trap request/acknowledge handshake with the core.
- mret restore of MIE from MPIE.
- Vectored mtvec mode.
- CSR set/clear operations.

It sits beside the core's decode/writeback stage, with interrupt lines arriving from the timer and UART peripherals.

Parameters:
NUM_IRQ, 16, number of interrupt sources (1..31); source i is mip/mie bit i, cause code i.
MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
HART_ID, 0, value returned by mhartid.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
csr_addr  in  12  CSR address for both read and write
csr_wdata  in  32  write operand
csr_op  in  2  00 none, 01 write, 10 set bits, 11 clear bits
csr_rdata  out  32  registered read data of csr_addr
irq_pend  in  NUM_IRQ  level interrupt requests
exc_valid  in  1  synchronous exception this cycle
exc_cause  in  5  exception cause code
exc_tval  in  32  exception value for mtval
exc_pc  in  32  PC of the faulting instruction
pc_next  in  32  PC the core will execute next (resume point for interrupts)
trap_ack  in  1  core accepted the trap at an instruction boundary
mret  in  1  core executing mret
trap_req  out  1  trap pending to core
trap_vector  out  32  target PC for the pending trap
mepc_out  out  32  current mepc (mret target)
mstatus_mie  out  1  global interrupt enable

Behaviour:
- Reset: mstatus, mie, mip, mepc, mcause, mtval, mscratch = 0; mtvec = MTVEC_RESET; csr_rdata = 0; trap_req = 0; FSM in IDLE.
- Read: csr_rdata is valid one cycle after csr_addr.
  - Implemented addresses: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip, 0xF14 mhartid.
  - Any other address reads 0.
- Write: takes effect at the next edge.
  - op 01 writes; 10 does reg | wdata; 11 does reg & ~wdata.
  - mip and mhartid are read-only.
  - mie bits at or above NUM_IRQ are hardwired to 0.
  - mtvec[1:0] accepts only 00 or 01; value 1x stores as 00.
- mip: registered copy of irq_pend each cycle (1-cycle latency).
- Arbitration: eligible = mip & mie when mstatus.MIE (bit 3) = 1. The lowest-index eligible bit wins.
- FSM:
  - IDLE: exc_valid has priority over interrupts. Either cause latches the cause/tval/epc candidate and moves to PEND. The trap_req register rises in that same edge.
  - PEND: trap_req = 1; the latched candidate is held stable even if irq_pend drops. The only exception is a later exc_valid, which overwrites an interrupt candidate.
  - PEND, on trap_ack:
    - mepc = exc_pc for an exception, pc_next for an interrupt.
    - mcause = {1, idx} for an interrupt, {0, exc_cause} for an exception.
    - mtval = exc_tval for an exception, 0 for an interrupt.
    - mstatus.MPIE (bit 7) = MIE; MIE = 0.
    - Go to IDLE; trap_req = 0 next cycle.
- trap_vector: mtvec base {mtvec[31:2], 00}. Vectored mode (mtvec[1:0] = 01) with an interrupt candidate gives base + 4*idx.
- mret (IDLE only): MIE = MPIE, MPIE = 1. mret in PEND is ignored.
- Simultaneous events:
  - trap_ack beats a same-cycle CSR write to mepc/mcause/mtval/mstatus.
  - A CSR write beats mret on mstatus.
  - exc_valid together with trap_ack commits the latched candidate; the new exception is then taken from IDLE next cycle.
- Reset mid-PEND: abandons the trap and returns to IDLE with all fields at their reset values.

Optional Feature:
CSR_COUNTERS_EN.
- Defined:
  - 64-bit mcycle increments every cycle after reset.
  - 64-bit minstret increments on input pulse instr_retire (extra port, width 1).
  - Readable at 0xB00/0xB80 (mcycle lo/hi) and 0xB02/0xB82 (minstret lo/hi).
  - Writable via csr_op; a write in the same cycle overrides the increment.
- Undefined: instr_retire port absent; those addresses read 0.

Decomposition:
- Package csr_pkg: CSR address constants, csr_op encodings, mstatus bit positions (MIE=3, MPIE=7), FSM state enum (IDLE, PEND), exception cause constants.
- One sub-module, csr_irq_arbiter:
  - Parametrised by NUM_IRQ; purely combinational priority encoder.
  - Outputs any_valid and idx[4:0].

Test Plan:
- Write mtvec=0x100, mie=0x0080, mstatus=0x8, then raise irq_pend[7] → trap_req 2 cycles later, trap_vector=0x100. After ack: mcause=0x8000_0007, mepc=pc_next, mstatus=0x80.
- Set mtvec=0x101, irq_pend bits 3 and 9 both enabled → idx 3 wins, trap_vector=0x10C, mcause=0x8000_0003.
- Interrupt in PEND then exc_valid with cause 2, tval 0xDEAD → after ack mcause=0x2, mtval=0xDEAD, mepc=exc_pc.
- After a trap, assert mret → mstatus.MIE=1, MPIE=1, mepc_out unchanged. mret asserted during PEND → no change.
- csr_op=10 then 11 on mscratch with 0xF0 over 0x0F → reads 0xFF, then 0x0F. Write to mip → mip still equals irq_pend.
- Assert reset while in PEND → trap_req=0 next cycle; mcause=0, mtvec=MTVEC_RESET. With CSR_COUNTERS_EN, mcycle reads 0 right after reset and then increments by 1 per cycle.
